instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Control sequencer for the 10-bit processor.
- Consumes the 2-bit timestep T from the step counter and latches instructions into an internal IR.
- Decodes {IR, T} into per-step datapath controls and drives the step counter's clear.
- Sits between instruction input (DIN) and the register file / ALU datapath.

Parameters:
- DATA_W, 10, instruction/data width; IR = [9:6] opcode, [5:3] rx, [2:0] ry.
- NUM_REGS, 8, general registers; width of one-hot R_IN/R_OUT; must equal 2**3.

Ports:
- CLKb  in  1  clock; all state updates on falling edge.
- CLR  in  1  reset, asynchronous, active-high.
- RUN  in  1  start request, sampled at T=0.
- T  in  2  current timestep from step counter.
- DIN  in  DATA_W  instruction word, valid while RUN=1 at T=0.
- IR_Q  out  DATA_W  latched instruction register.
- R_IN  out  NUM_REGS  one-hot register write enable.
- R_OUT  out  NUM_REGS  one-hot register bus drive.
- DIN_OUT  out  1  drive DIN onto bus (immediate).
- A_IN  out  1  load ALU operand register A.
- G_IN  out  1  load ALU result register G.
- G_OUT  out  1  drive G onto bus.
- ALU_OP  out  3  ALU function = IR[8:6], valid when G_IN=1, else 0.
- DONE  out  1  final step of current instruction.
- BUSY  out  1  instruction in flight.
- STEP_CLR  out  1  synchronous clear request to step counter.

Behaviour:
- Reset (CLR=1, any time, including mid-instruction): IR_Q=0, BUSY=0, all control outputs 0, STEP_CLR=1. On CLR deassert, the block idles at T=0.
- Registered state: IR_Q, BUSY. Controls, DONE, and STEP_CLR are combinational from {IR_Q, BUSY, T, RUN}.
- T=0 fetch: if RUN=1, IR_Q<=DIN and BUSY<=1 at the falling edge. If RUN=0, IR_Q holds and STEP_CLR=1, so the counter stays at 0.
- Opcodes: 0000 MV, 0001 MVI, 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT; 1xxx illegal.
- T=1:
  - MV: R_OUT[ry], R_IN[rx], DONE.
  - MVI: DIN_OUT, R_IN[rx], DONE.
  - ALU ops: R_OUT[rx], A_IN.
  - Illegal: DONE only, no writes.
- T=2:
  - ADD..XOR: R_OUT[ry], G_IN, ALU_OP=IR[8:6].
  - NOT: G_IN, ALU_OP=3'b111, no R_OUT.
- T=3: ALU ops: G_OUT, R_IN[rx], DONE.
- STEP_CLR = CLR | DONE | (T==0 & ~RUN). The consumer samples it at the falling edge, so the counter returns to 0 instead of incrementing.
- At the falling edge where DONE=1, BUSY<=0.
- Back-to-back: RUN held high gives a fetch at the very next T=0 with no idle cycle.
- Latency: MV/MVI/illegal take 2 steps incl. fetch; ALU ops take 4.
- At most one R_IN bit and one R_OUT bit high at any time. G_OUT and DIN_OUT are never high with R_OUT.
- T=1..3 while BUSY=0 (counter out of sync): all controls 0, STEP_CLR=1.
- RUN changes during T=1..3 are ignored.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: adds output ILLEGAL (1 bit), set at the T=1 falling edge of an illegal opcode, sticky until CLR. While ILLEGAL=1, fetches are blocked: STEP_CLR=1, BUSY stays 0, IR_Q holds.
- Undefined: no ILLEGAL port; illegal opcodes complete at T=1 as 2-step NOPs.

Test Plan:
- CLR pulse mid-ADD at T=2 -> IR_Q=0, BUSY=0, G_IN=0, STEP_CLR=1 immediately, with no clock edge required.
- RUN=1, DIN=0001_010_000 (MVI r2) at T=0 -> T=1: DIN_OUT=1, R_IN=8'b0000_0100, DONE=1, STEP_CLR=1; next step T=0, BUSY=0.
- DIN=0010_001_011 (ADD r1,r3) -> T1: R_OUT=8'h02, A_IN=1; T2: R_OUT=8'h08, G_IN=1, ALU_OP=3'b010; T3: G_OUT=1, R_IN=8'h02, DONE=1.
- RUN=0 held 5 edges at T=0 -> IR_Q unchanged, STEP_CLR=1 throughout; RUN high for MV then ADD back-to-back -> second fetch at the immediately following T=0.
- DIN=1010_000_000 -> T=1: DONE=1, no R_IN. With ILLEGAL_OP_TRAP_EN: ILLEGAL=1 after that edge, and a subsequent RUN=1 does not fetch until CLR.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: sequencer control bus; ILLEGAL exists only when ILLEGAL_OP_TRAP_EN is defined
interface instr_sequencer_if #(
  parameter int DATA_W   = 10,
  parameter int NUM_REGS = 8
);
  logic                RUN;
  logic [1:0]          T;
  logic [DATA_W-1:0]   DIN;
  logic [DATA_W-1:0]   IR_Q;
  logic [NUM_REGS-1:0] R_IN;
  logic [NUM_REGS-1:0] R_OUT;
  logic                DIN_OUT;
  logic                A_IN;
  logic                G_IN;
  logic                G_OUT;
  logic [2:0]          ALU_OP;
  logic                DONE;
  logic                BUSY;
  logic                STEP_CLR;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                ILLEGAL;
`endif
  modport slave (
    input  RUN, T, DIN,
    output IR_Q, R_IN, R_OUT, DIN_OUT, A_IN, G_IN, G_OUT, ALU_OP, DONE, BUSY, STEP_CLR
`ifdef ILLEGAL_OP_TRAP_EN
    , output ILLEGAL
`endif
  );
  modport master (
    output RUN, T, DIN,
    input  IR_Q, R_IN, R_OUT, DIN_OUT, A_IN, G_IN, G_OUT, ALU_OP, DONE, BUSY, STEP_CLR
`ifdef ILLEGAL_OP_TRAP_EN
    , input ILLEGAL
`endif
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode sequencer for the 10-bit processor; ILLEGAL_OP_TRAP_EN adds a sticky illegal-opcode trap
module instr_sequencer #(
  parameter int DATA_W   = 10,
  parameter int NUM_REGS = 8
) (
  input  logic               CLKb,
  input  logic               CLR,
  instr_sequencer_if.slave   bus
);
  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_MVI = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0111;
  logic [DATA_W-1:0]   r_ir;
  logic                r_busy;
  logic [3:0]          w_op;
  logic [2:0]          w_rx, w_ry;
  logic [NUM_REGS-1:0] w_one;
  logic                w_t0, w_t1, w_t2, w_t3, w_act;
  logic                w_mv, w_mvi, w_bad, w_alu, w_not;
  logic                w_done, w_fetch, w_gin, w_trap;
  assign w_op  = r_ir[9:6];
  assign w_rx  = r_ir[5:3];
  assign w_ry  = r_ir[2:0];
  assign w_one = NUM_REGS'(1);
  assign w_t0  = bus.T == 2'd0;
  assign w_t1  = bus.T == 2'd1;
  assign w_t2  = bus.T == 2'd2;
  assign w_t3  = bus.T == 2'd3;
  assign w_act = r_busy & ~w_t0;
  assign w_mv  = w_op == OP_MV;
  assign w_mvi = w_op == OP_MVI;
  assign w_bad = w_op[3];
  assign w_not = w_op == OP_NOT;
  assign w_alu = ~w_op[3] & (w_op[2:1] != 2'b00);
  assign w_done  = w_act & ((w_t1 & (w_mv | w_mvi | w_bad)) | (w_t3 & w_alu));
  assign w_fetch = w_t0 & bus.RUN & ~w_trap;
  assign w_gin   = w_act & w_t2 & w_alu;
`ifdef ILLEGAL_OP_TRAP_EN
  logic r_ill;
  assign w_trap      = r_ill;
  assign bus.ILLEGAL = r_ill;
  // latch an illegal opcode at its T=1 step; only CLR releases the trap
  always_ff @(negedge CLKb or posedge CLR)
    if (CLR) r_ill <= 1'b0;
    else if (w_act & w_t1 & w_bad) r_ill <= 1'b1;
`else
  assign w_trap = 1'b0;
`endif
  // fetch at T=0 when RUN is high; drop BUSY at the step that finishes the instruction
  always_ff @(negedge CLKb or posedge CLR)
    if (CLR) begin
      r_ir   <= '0;
      r_busy <= 1'b0;
    end else if (w_fetch) begin
      r_ir   <= bus.DIN;
      r_busy <= 1'b1;
    end else if (w_done) r_busy <= 1'b0;
  assign bus.IR_Q    = r_ir;
  assign bus.BUSY    = r_busy;
  assign bus.R_IN    = (w_act & ((w_t1 & (w_mv | w_mvi)) | (w_t3 & w_alu))) ? w_one << w_rx : '0;
  assign bus.R_OUT   = (w_act & w_t1 & (w_mv | w_alu)) ? w_one << (w_mv ? w_ry : w_rx) :
                       (w_gin & ~w_not) ? w_one << w_ry : '0;
  assign bus.DIN_OUT = w_act & w_t1 & w_mvi;
  assign bus.A_IN    = w_act & w_t1 & w_alu;
  assign bus.G_IN    = w_gin;
  assign bus.G_OUT   = w_act & w_t3 & w_alu;
  assign bus.ALU_OP  = w_gin ? r_ir[8:6] : 3'b000;
  assign bus.DONE    = w_done;
  assign bus.STEP_CLR = CLR | w_done | (w_t0 & (~bus.RUN | w_trap)) | (~w_t0 & ~r_busy);
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed plus random stimulus checked against an instruction-level model with a step counter
module tb_instr_sequencer;
  typedef struct packed {
    logic [2:0] pad;
    logic       ill;
    logic [9:0] ir;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       din_out;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic [2:0] alu;
    logic       done;
    logic       busy;
    logic       sclr;
  } out_t;
  localparam logic [9:0] MVI_R2  = 10'b0001_010_000;
  localparam logic [9:0] ADD_13  = 10'b0010_001_011;
  localparam logic [9:0] MV_56   = 10'b0000_101_110;
  localparam logic [9:0] SUB_42  = 10'b0011_100_010;
  localparam logic [9:0] ILL_OP  = 10'b1010_000_000;
  logic CLKb = 1'b0;
  logic CLR;
  int   n_vec = 0;
  int   n_err = 0;
  logic [9:0] m_ir;
  logic       m_busy, m_ill;
  logic [1:0] m_t;
  out_t snap, snap_clr, e;
  instr_sequencer_if #(.DATA_W(10), .NUM_REGS(8)) bus ();
  instr_sequencer #(.DATA_W(10), .NUM_REGS(8)) dut (.CLKb(CLKb), .CLR(CLR), .bus(bus));
  always #5 CLKb = ~CLKb;
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t (T=%0d)", tag, got, want, $time, bus.T);
    end
  endtask
  function automatic logic [7:0] hot(input logic [2:0] r);
    return 8'(1) << r;
  endfunction
  function automatic out_t observe();
    out_t o;
    o = '0;
`ifdef ILLEGAL_OP_TRAP_EN
    o.ill = bus.ILLEGAL;
`endif
    o.ir = bus.IR_Q; o.rin = bus.R_IN; o.rout = bus.R_OUT;
    o.din_out = bus.DIN_OUT; o.a_in = bus.A_IN; o.g_in = bus.G_IN; o.g_out = bus.G_OUT;
    o.alu = bus.ALU_OP; o.done = bus.DONE; o.busy = bus.BUSY; o.sclr = bus.STEP_CLR;
    return o;
  endfunction
  function automatic out_t predict(input logic [1:0] t, input logic run, input logic clr);
    out_t o;
    logic [3:0] op;
    logic [2:0] rx, ry;
    o = '0;
    op = m_ir[9:6]; rx = m_ir[5:3]; ry = m_ir[2:0];
    if (clr) begin
      o.sclr = 1'b1;
      return o;
    end
    o.ir = m_ir; o.busy = m_busy; o.ill = m_ill;
    if (m_busy && t != 2'd0) begin
      if (t == 2'd1) begin
        if (op >= 4'd8) o.done = 1'b1;
        else if (op == 4'd0) begin o.rout = hot(ry); o.rin = hot(rx); o.done = 1'b1; end
        else if (op == 4'd1) begin o.din_out = 1'b1; o.rin = hot(rx); o.done = 1'b1; end
        else begin o.rout = hot(rx); o.a_in = 1'b1; end
      end else if (t == 2'd2) begin
        if (op >= 4'd2 && op <= 4'd6) begin o.rout = hot(ry); o.g_in = 1'b1; o.alu = op[2:0]; end
        else if (op == 4'd7) begin o.g_in = 1'b1; o.alu = 3'b111; end
      end else if (op >= 4'd2 && op <= 4'd7) begin
        o.g_out = 1'b1; o.rin = hot(rx); o.done = 1'b1;
      end
    end
    o.sclr = o.done || (t == 2'd0 && (!run || m_ill)) || (t != 2'd0 && !m_busy);
    return o;
  endfunction
  task automatic step(input logic run, input logic [9:0] din, input logic clr);
    @(posedge CLKb);
    bus.T = m_t; bus.RUN = run; bus.DIN = din;
    if (clr) begin
      CLR = 1'b1;
      #1;
      snap_clr = observe();
      check("clr_async", snap_clr, predict(m_t, run, 1'b1));
      m_ir = '0; m_busy = 1'b0; m_ill = 1'b0; m_t = 2'd0;
      CLR = 1'b0;
      bus.T = 2'd0;
    end
    #1;
    e = predict(m_t, run, 1'b0);
    snap = observe();
    check("step", snap, e);
    @(negedge CLKb);
    if (m_t == 2'd0 && run && !m_ill) begin m_ir = din; m_busy = 1'b1; end
    else if (e.done) m_busy = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    if (e.done && m_t == 2'd1 && m_ir[9]) m_ill = 1'b1;
`endif
    m_t = e.sclr ? 2'd0 : m_t + 2'd1;
  endtask
  initial begin
    CLR = 1'b1; bus.RUN = 1'b0; bus.T = 2'd0; bus.DIN = '0;
    m_ir = '0; m_busy = 1'b0; m_ill = 1'b0; m_t = 2'd0;
    #1;
    check("reset", observe(), predict(2'd0, 1'b0, 1'b1));
    #1 CLR = 1'b0;
    step(1'b1, MVI_R2, 1'b0);
    step(1'b0, '0, 1'b0);
    check("mvi_din_out", 40'(snap.din_out), 40'(1'b1));
    check("mvi_rin", 40'(snap.rin), 40'(8'h04));
    check("mvi_done", 40'(snap.done), 40'(1'b1));
    check("mvi_sclr", 40'(snap.sclr), 40'(1'b1));
    step(1'b0, '0, 1'b0);
    check("mvi_after_busy", 40'(snap.busy), 40'(1'b0));
    step(1'b1, ADD_13, 1'b0);
    step(1'b0, '0, 1'b0);
    check("add_t1_rout", 40'(snap.rout), 40'(8'h02));
    check("add_t1_ain", 40'(snap.a_in), 40'(1'b1));
    step(1'b0, '0, 1'b0);
    check("add_t2_rout", 40'(snap.rout), 40'(8'h08));
    check("add_t2_gin", 40'(snap.g_in), 40'(1'b1));
    check("add_t2_alu", 40'(snap.alu), 40'(3'b010));
    step(1'b0, '0, 1'b0);
    check("add_t3_gout", 40'(snap.g_out), 40'(1'b1));
    check("add_t3_rin", 40'(snap.rin), 40'(8'h02));
    check("add_t3_done", 40'(snap.done), 40'(1'b1));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 10'($urandom), 1'b0);
      check("idle_ir", 40'(snap.ir), 40'(ADD_13));
      check("idle_sclr", 40'(snap.sclr), 40'(1'b1));
    end
    step(1'b1, MV_56, 1'b0);
    step(1'b1, SUB_42, 1'b0);
    check("mv_rout", 40'(snap.rout), 40'(8'h40));
    check("mv_rin", 40'(snap.rin), 40'(8'h20));
    step(1'b1, SUB_42, 1'b0);
    step(1'b0, '0, 1'b0);
    check("b2b_ir", 40'(snap.ir), 40'(SUB_42));
    check("b2b_busy", 40'(snap.busy), 40'(1'b1));
    check("b2b_rout", 40'(snap.rout), 40'(8'h10));
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, ILL_OP, 1'b0);
    step(1'b0, '0, 1'b0);
    check("ill_done", 40'(snap.done), 40'(1'b1));
    check("ill_rin", 40'(snap.rin), 40'(8'h00));
`ifdef ILLEGAL_OP_TRAP_EN
    step(1'b1, MV_56, 1'b0);
    check("trap_flag", 40'(snap.ill), 40'(1'b1));
    check("trap_sclr", 40'(snap.sclr), 40'(1'b1));
    step(1'b1, MV_56, 1'b0);
    check("trap_busy", 40'(snap.busy), 40'(1'b0));
    check("trap_ir", 40'(snap.ir), 40'(ILL_OP));
    step(1'b0, '0, 1'b1);
    check("trap_clr", 40'(snap_clr.ill), 40'(1'b0));
`endif
    step(1'b1, ADD_13, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    check("clr_ir", 40'(snap_clr.ir), 40'(10'd0));
    check("clr_busy", 40'(snap_clr.busy), 40'(1'b0));
    check("clr_gin", 40'(snap_clr.g_in), 40'(1'b0));
    check("clr_sclr", 40'(snap_clr.sclr), 40'(1'b1));
    for (int i = 0; i < 600; i++) begin
      if (!m_busy && m_t == 2'd0 && $urandom_range(15) == 0) m_t = 2'($urandom_range(3, 1));
      step($urandom_range(3) != 0, 10'($urandom),
           ($urandom_range(39) == 0) || (m_ill && $urandom_range(3) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
